// File: rtl/twiddle_cmul.sv
// Joins a sample stream with a sign-magnitude twiddle stream and multiplies each
// lane by cos - j*sin through a 3-stage stall-able pipeline with rounding and saturation.
module twiddle_cmul #(
  parameter int PARL    = 4,
  parameter int DW      = 16,
  parameter int TW_FRAC = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [PARL*DW-1:0]            s_re,
  input  logic [PARL*DW-1:0]            s_im,
  input  logic                          tw_valid,
  output logic                          tw_ready,
  input  logic [PARL*(TW_FRAC+1)-1:0]   tw_cos,
  input  logic [PARL-1:0]               tw_cos_sign,
  input  logic [PARL*(TW_FRAC+1)-1:0]   tw_sin,
  input  logic [PARL-1:0]               tw_sin_sign,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [PARL*DW-1:0]            m_re,
  output logic [PARL*DW-1:0]            m_im
);

  localparam int MW = TW_FRAC + 1;       // twiddle magnitude width
  localparam int CW = TW_FRAC + 2;       // signed twiddle width
  localparam int PW = DW + TW_FRAC + 2;  // product width
  localparam int SW = PW + 1;            // sum width

  localparam logic signed [SW-1:0] RND     = SW'(2 ** (TW_FRAC - 1));
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (DW - 1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
    logic signed [DW-1:0] y;
    if (x > SAT_MAX) begin
      y = SAT_MAX[DW-1:0];
    end else if (x < SAT_MIN) begin
      y = SAT_MIN[DW-1:0];
    end else begin
      y = x[DW-1:0];
    end
    return y;
  endfunction

  logic adv;
  logic xfer;
  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;

  // A single stall enable freezes every stage whenever the output is held.
  assign adv      = !v3_q || m_ready;
  assign s_ready  = tw_valid && adv && !rst;
  assign tw_ready = s_valid && adv && !rst;
  assign xfer     = s_valid && tw_valid && adv;

  assign v1_d = xfer;
  assign v2_d = v1_q;
  assign v3_d = v2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  assign m_valid = v3_q;

  for (genvar gi = 0; gi < PARL; gi++) begin : g_lane
    logic signed [CW-1:0] c_mag, s_mag;
    logic signed [CW-1:0] c_d, s_d, c1_q, s1_q;
    logic signed [DW-1:0] re_d, im_d, re1_q, im1_q;
    logic signed [PW-1:0] rc_d, is_d, ic_d, rs_d;
    logic signed [PW-1:0] rc_q, is_q, ic_q, rs_q;
    logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;
    logic signed [DW-1:0] ore_d, oim_d, ore_q, oim_q;

    assign c_mag = {1'b0, tw_cos[gi*MW +: MW]};
    assign s_mag = {1'b0, tw_sin[gi*MW +: MW]};
    assign c_d   = tw_cos_sign[gi] ? -c_mag : c_mag;
    assign s_d   = tw_sin_sign[gi] ? -s_mag : s_mag;
    assign re_d  = s_re[gi*DW +: DW];
    assign im_d  = s_im[gi*DW +: DW];

    assign rc_d = PW'(re1_q) * PW'(c1_q);
    assign is_d = PW'(im1_q) * PW'(s1_q);
    assign ic_d = PW'(im1_q) * PW'(c1_q);
    assign rs_d = PW'(re1_q) * PW'(s1_q);

    // Multiplying by cos - j*sin: real gains +im*sin, imag loses re*sin.
    assign sum_re = SW'(rc_q) + SW'(is_q);
    assign sum_im = SW'(ic_q) - SW'(rs_q);
    assign rnd_re = (sum_re + RND) >>> TW_FRAC;
    assign rnd_im = (sum_im + RND) >>> TW_FRAC;
    assign ore_d  = sat(rnd_re);
    assign oim_d  = sat(rnd_im);

    always_ff @(posedge clk) begin
      if (rst) begin
        re1_q <= '0;
        im1_q <= '0;
        c1_q  <= '0;
        s1_q  <= '0;
        rc_q  <= '0;
        is_q  <= '0;
        ic_q  <= '0;
        rs_q  <= '0;
        ore_q <= '0;
        oim_q <= '0;
      end else if (adv) begin
        re1_q <= re_d;
        im1_q <= im_d;
        c1_q  <= c_d;
        s1_q  <= s_d;
        rc_q  <= rc_d;
        is_q  <= is_d;
        ic_q  <= ic_d;
        rs_q  <= rs_d;
        ore_q <= ore_d;
        oim_q <= oim_d;
      end
    end

    assign m_re[gi*DW +: DW] = ore_q;
    assign m_im[gi*DW +: DW] = oim_q;
  end

  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_re) && $stable(m_im)));

endmodule
